// File: rtl/touch_key_if.sv
// Start/press request and emulated sensor outputs of the touch-key generator.
`timescale 1ns/1ps

interface touch_key_if;
    logic       start;
    logic [3:0] press_num;
    logic       busy;
    logic       done;
    logic       touch_key;

    modport master (
        output start,
        output press_num,
        input  busy,
        input  done,
        input  touch_key
    );

    modport slave (
        input  start,
        input  press_num,
        output busy,
        output done,
        output touch_key
    );
endinterface

// File: rtl/touch_key_gen.sv
// Touch-sensor emulator: plays press_num presses of bounce, stable high and low gap.
`timescale 1ns/1ps

module touch_key_gen #(
    parameter int unsigned PRESS_CYC  = 100,
    parameter int unsigned GAP_CYC    = 50,
    parameter int unsigned BOUNCE_NUM = 4,
    parameter int unsigned BOUNCE_CYC = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    touch_key_if.slave  tk_if
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE,
        ST_PRESS,
        ST_GAP,
        ST_DONE
    } state_e;

    // Each press starts with bounce, or straight with the stable high when there is none.
    localparam state_e             FIRST_ST  = (BOUNCE_NUM == 0) ? ST_PRESS : ST_BOUNCE;
    localparam logic [CNT_W-1:0]   FIRST_CNT = (BOUNCE_NUM == 0) ? CNT_W'(PRESS_CYC - 1)
                                                                 : CNT_W'(BOUNCE_CYC - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(BOUNCE_NUM - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   bidx_q;
    logic [IDX_W-1:0]   pcnt_q;
    logic               touch_q;
    logic               busy_q;
    logic               done_q;

    // Counter holds remaining cycles minus one of the current segment.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            pcnt_q  <= '0;
            touch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    touch_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (tk_if.start && (tk_if.press_num != '0)) begin
                        pcnt_q  <= tk_if.press_num;
                        busy_q  <= 1'b1;
                        state_q <= FIRST_ST;
                        cnt_q   <= FIRST_CNT;
                        bidx_q  <= '0;
                        touch_q <= 1'b1;
                    end else if (tk_if.start) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BOUNCE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (bidx_q == LAST_IDX) begin
                        state_q <= ST_PRESS;
                        cnt_q   <= CNT_W'(PRESS_CYC - 1);
                        touch_q <= 1'b1;
                    end else begin
                        // Next segment index flips parity: high on even, low on odd.
                        bidx_q  <= bidx_q + IDX_W'(1);
                        cnt_q   <= CNT_W'(BOUNCE_CYC - 1);
                        touch_q <= bidx_q[0];
                    end
                end
                ST_PRESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= ST_GAP;
                        cnt_q   <= CNT_W'(GAP_CYC - 1);
                        touch_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        pcnt_q <= pcnt_q - IDX_W'(1);
                        if (pcnt_q != IDX_W'(1)) begin
                            state_q <= FIRST_ST;
                            cnt_q   <= FIRST_CNT;
                            bidx_q  <= '0;
                            touch_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            touch_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    touch_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tk_if.touch_key = touch_q;
    assign tk_if.busy      = busy_q;
    assign tk_if.done      = done_q;

endmodule
